// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC scan sequencer.
package adc_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_NEXT
    } state_t;

    // Channel index width; a 2-channel mux still needs one select bit.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// Control, SAR ADC and result signals of the scan sequencer.
interface adc_scan_sequencer_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = adc_pkg::DATA_W_DEF
);
    localparam int CH_W = adc_pkg::ch_width(NUM_CH);

    logic              enable;
    logic              single_shot;
    logic [NUM_CH-1:0] ch_mask;
    logic              adc_start;
    logic              adc_busy;
    logic              adc_valid;
    logic [DATA_W-1:0] adc_data;
    logic [CH_W-1:0]   mux_sel;
    logic              res_valid;
    logic [CH_W-1:0]   res_ch;
    logic [DATA_W-1:0] res_data;
    logic              scan_done;
    logic              seq_busy;
    logic              timeout_err;

    modport master (
        output enable, single_shot, ch_mask, adc_busy, adc_valid, adc_data,
        input  adc_start, mux_sel, res_valid, res_ch, res_data, scan_done,
               seq_busy, timeout_err
    );

    modport slave (
        input  enable, single_shot, ch_mask, adc_busy, adc_valid, adc_data,
        output adc_start, mux_sel, res_valid, res_ch, res_data, scan_done,
               seq_busy, timeout_err
    );

endinterface

// File: rtl/adc_chan_pick.sv
// Finds the lowest set mask bit at or above a start index.
module adc_chan_pick
    import adc_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [CH_W:0]     i_start,
    output logic              o_found,
    output logic [CH_W-1:0]   o_idx
);

    // Descending scan so the lowest qualifying index is written last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_mask[i] && (i >= int'(i_start))) begin
                o_found = 1'b1;
                o_idx   = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scans enabled analog mux channels through a SAR ADC: settle, start, wait, deliver.
//
// state       | meaning
// S_IDLE      | no scan; waits for enable with a non-empty mask
// S_SETTLE    | mux switched, settling down-counter running
// S_START     | one-clock adc_start pulse, timeout timer loaded
// S_WAIT_BUSY | waiting for ADC busy (or an early valid)
// S_WAIT_DONE | ADC busy, waiting for valid with busy low
// S_NEXT      | deliver result, pick next channel or end the pass
module adc_scan_sequencer
    import adc_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adc_scan_sequencer_if.slave  bus
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    state_t             r_state;
    state_t             w_next;
    logic [NUM_CH-1:0]  r_mask;
    logic               r_single;
    logic [CH_W-1:0]    r_mux_sel;
    logic [SET_W-1:0]   r_settle_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [DATA_W-1:0]  r_res_data;
    logic [CH_W-1:0]    r_res_ch;
    logic               r_have_res;
    logic               r_timeout_err;

    logic               w_lo_found;
    logic [CH_W-1:0]    w_lo_idx;
    logic               w_nx_found;
    logic [CH_W-1:0]    w_nx_idx;
    logic [CH_W:0]      w_nx_start;
    logic               w_in_wait;
    logic               w_capture;
    logic               w_timeout;
    logic               w_start_scan;
    logic               w_pass_end;
    logic               w_continue;
    logic               w_restart;
    logic               w_advance;
    logic               w_load_settle;

    adc_chan_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick_lo (
        .i_mask  (bus.ch_mask),
        .i_start ('0),
        .o_found (w_lo_found),
        .o_idx   (w_lo_idx)
    );

    assign w_nx_start = (CH_W + 1)'(r_mux_sel) + (CH_W + 1)'(1);

    adc_chan_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick_nx (
        .i_mask  (r_mask),
        .i_start (w_nx_start),
        .o_found (w_nx_found),
        .o_idx   (w_nx_idx)
    );

    assign w_in_wait     = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
    // An ADC that never shows busy may report valid straight from WAIT_BUSY.
    assign w_capture     = w_in_wait && bus.adc_valid &&
                           ((r_state == S_WAIT_BUSY) || !bus.adc_busy);
    assign w_timeout     = w_in_wait && !w_capture && (r_to_cnt == '0);
    assign w_start_scan  = (r_state == S_IDLE) && bus.enable && w_lo_found;
    assign w_advance     = (r_state == S_NEXT) && w_nx_found;
    assign w_pass_end    = (r_state == S_NEXT) && !w_nx_found;
    assign w_continue    = w_pass_end && !r_single && bus.enable;
    assign w_restart     = w_continue && w_lo_found;
    assign w_load_settle = w_start_scan || w_advance || w_restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        bus.adc_start   = 1'b0;
        bus.res_valid   = 1'b0;
        bus.scan_done   = 1'b0;
        bus.seq_busy    = 1'b1;
        bus.mux_sel     = r_mux_sel;
        bus.res_ch      = r_res_ch;
        bus.res_data    = r_res_data;
        bus.timeout_err = r_timeout_err;
        case (r_state)
            S_IDLE: begin
                bus.seq_busy = 1'b0;
                if (w_start_scan) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_settle_cnt == '0) w_next = S_START;
            end
            S_START: begin
                bus.adc_start = 1'b1;
                w_next        = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (w_capture || w_timeout) w_next = S_NEXT;
                else if (bus.adc_busy)      w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (w_capture || w_timeout) w_next = S_NEXT;
            end
            S_NEXT: begin
                bus.res_valid = r_have_res;
                bus.scan_done = w_pass_end;
                if (w_advance || w_restart) w_next = S_SETTLE;
                else                        w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask        <= '0;
            r_single      <= 1'b0;
            r_mux_sel     <= '0;
            r_settle_cnt  <= '0;
            r_to_cnt      <= '0;
            r_res_data    <= '0;
            r_res_ch      <= '0;
            r_have_res    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_start_scan || w_continue) begin
                r_mask   <= bus.ch_mask;
                r_single <= bus.single_shot;
            end

            if (w_start_scan || w_restart) begin
                r_mux_sel <= w_lo_idx;
            end else if (w_advance) begin
                r_mux_sel <= w_nx_idx;
            end

            if (w_load_settle) begin
                r_settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
            end else if ((r_state == S_SETTLE) && (r_settle_cnt != '0)) begin
                r_settle_cnt <= r_settle_cnt - SET_W'(1);
            end

            if (r_state == S_START) begin
                r_to_cnt   <= TO_W'(TIMEOUT_CYCLES - 1);
                r_have_res <= 1'b0;
            end else if (w_in_wait && (r_to_cnt != '0)) begin
                r_to_cnt <= r_to_cnt - TO_W'(1);
            end

            if (w_capture) begin
                r_res_data <= bus.adc_data;
                r_res_ch   <= r_mux_sel;
                r_have_res <= 1'b1;
            end

            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a scan-order model and ADC responder.
module tb_adc_scan_sequencer;

    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 8;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;

    typedef struct {
        int ch;
        int data;
    } res_t;

    logic clk;
    logic rst_n;

    adc_scan_sequencer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    adc_scan_sequencer #(
        .NUM_CH         (NUM_CH),
        .DATA_W         (DATA_W),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   adc_mode = 0;
    int   adc_lat  = 3;
    bit   dead_en  = 1'b0;
    int   dead_ch  = 0;

    int   exp_start_q[$];
    res_t exp_res_q[$];
    int   exp_done   = 0;
    int   done_seen  = 0;
    int   starts_seen = 0;
    int   log_ch[$];
    int   log_data[$];
    int   prev_mux = 0;
    bit   changed  = 1'b0;
    int   last_change = 0;
    bit   prev_to  = 1'b0;
    int   to_rise_cyc = 0;
    int   dead_start_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected conversions of one pass: every enabled channel in ascending order.
    task automatic model_pass(input logic [NUM_CH-1:0] m);
        for (int c = 0; c < NUM_CH; c++) begin
            if (m[c]) begin
                exp_start_q.push_back(c);
                if (!(dead_en && c == dead_ch))
                    exp_res_q.push_back('{ch: c, data: c * 16 + 5});
            end
        end
        exp_done++;
    endtask

    task automatic start_scan(input logic [NUM_CH-1:0] m, input bit single, input bit hold);
        @(posedge clk) #1;
        bus.ch_mask     = m;
        bus.single_shot = single;
        bus.enable      = 1'b1;
        if (!hold) begin
            @(posedge clk) #1;
            bus.enable = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name, input int lim);
        int n = 0;
        while (bus.seq_busy !== 1'b0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(bus.seq_busy), 0);
    endtask

    task automatic check_model(input string name);
        chk({name, "_starts_left"}, exp_start_q.size(), 0);
        chk({name, "_res_left"}, exp_res_q.size(), 0);
        chk({name, "_done_cnt"}, done_seen, exp_done);
    endtask

    // SAR ADC responder: busy (mode 0) then a one-cycle valid carrying ch*16+5.
    initial begin
        int ch;
        bus.adc_busy  = 1'b0;
        bus.adc_valid = 1'b0;
        bus.adc_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.adc_start) begin
                ch = int'(bus.mux_sel);
                if (!(dead_en && ch == dead_ch)) begin
                    @(posedge clk) #1;
                    if (adc_mode == 0) bus.adc_busy = 1'b1;
                    repeat (adc_lat) @(posedge clk);
                    #1;
                    bus.adc_busy  = 1'b0;
                    bus.adc_valid = 1'b1;
                    bus.adc_data  = DATA_W'(ch * 16 + 5);
                    @(posedge clk) #1;
                    bus.adc_valid = 1'b0;
                end
            end
        end
    end

    // Compare process: every cycle against the model and the reset rules.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("reset_flags", int'({bus.adc_start, bus.res_valid, bus.scan_done,
                                         bus.seq_busy, bus.timeout_err}), 0);
                chk("reset_regs", int'(bus.mux_sel) + int'(bus.res_ch) + int'(bus.res_data), 0);
                prev_mux = int'(bus.mux_sel);
                changed  = 1'b0;
                prev_to  = 1'b0;
            end else begin
                if (!bus.seq_busy)
                    chk("idle_quiet", int'({bus.adc_start, bus.res_valid, bus.scan_done}), 0);
                if (int'(bus.mux_sel) != prev_mux) begin
                    prev_mux    = int'(bus.mux_sel);
                    last_change = cyc;
                    changed     = 1'b1;
                end
                if (bus.adc_start) begin
                    starts_seen++;
                    if (exp_start_q.size() == 0) chk("start_unexpected", 1, 0);
                    else chk("start_ch", int'(bus.mux_sel), exp_start_q.pop_front());
                    if (changed) chk("settle_gap", cyc - last_change, SETTLE);
                    changed = 1'b0;
                    if (dead_en && int'(bus.mux_sel) == dead_ch) dead_start_cyc = cyc;
                end
                if (bus.res_valid) begin
                    log_ch.push_back(int'(bus.res_ch));
                    log_data.push_back(int'(bus.res_data));
                    if (exp_res_q.size() == 0) begin
                        chk("res_unexpected", 1, 0);
                    end else begin
                        e = exp_res_q.pop_front();
                        chk("res_ch", int'(bus.res_ch), e.ch);
                        chk("res_data", int'(bus.res_data), e.data);
                    end
                end
                if (bus.scan_done) done_seen++;
                if (bus.timeout_err && !prev_to) to_rise_cyc = cyc;
                prev_to = bus.timeout_err;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        int t1_exp[4] = '{5, 21, 37, 53};
        int t2_exp[4] = '{1, 3, 1, 3};
        int t4_exp[3] = '{0, 1, 3};

        rst_n           = 1'b1;
        bus.enable      = 1'b0;
        bus.single_shot = 1'b0;
        bus.ch_mask     = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Full mask, single shot.
        log_ch.delete(); log_data.delete();
        base = done_seen;
        model_pass(4'b1111);
        start_scan(4'b1111, 1'b1, 1'b0);
        wait_idle("t1_idle", 400);
        check_model("t1");
        chk("t1_res_cnt", log_data.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < log_data.size()) chk("t1_data_lit", log_data[i], t1_exp[i]);
        chk("t1_one_done", done_seen - base, 1);
        chk("t1_no_timeout", int'(bus.timeout_err), 0);

        // Continuous scan over 1010, valid without busy, enable dropped during 2nd-pass ch3.
        adc_mode = 1;
        log_ch.delete(); log_data.delete();
        model_pass(4'b1010);
        model_pass(4'b1010);
        base = starts_seen;
        start_scan(4'b1010, 1'b0, 1'b1);
        n = 0;
        while (starts_seen < base + 4 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t2_fourth_start", (starts_seen >= base + 4) ? 1 : 0, 1);
        @(posedge clk) #1;
        bus.enable = 1'b0;
        wait_idle("t2_idle", 400);
        check_model("t2");
        chk("t2_res_cnt", log_ch.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < log_ch.size()) chk("t2_ch_lit", log_ch[i], t2_exp[i]);
        adc_mode = 0;

        // Empty mask with enable high, plus a stray adc_valid while idle.
        base = starts_seen;
        @(posedge clk) #1;
        bus.ch_mask = '0;
        bus.enable  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                bus.adc_valid = 1'b1;
                bus.adc_data  = 8'd99;
            end
            if (i == 11) bus.adc_valid = 1'b0;
            @(negedge clk);
            chk("t3_seq_busy", int'(bus.seq_busy), 0);
            chk("t3_adc_start", int'(bus.adc_start), 0);
            @(posedge clk) #1;
        end
        bus.enable = 1'b0;
        chk("t3_no_starts", starts_seen - base, 0);

        // ch2 never answers: timeout, ch3 still converted.
        dead_en = 1'b1;
        dead_ch = 2;
        log_ch.delete(); log_data.delete();
        model_pass(4'b1111);
        start_scan(4'b1111, 1'b1, 1'b0);
        wait_idle("t4_idle", 600);
        check_model("t4");
        chk("t4_timeout_err", int'(bus.timeout_err), 1);
        // Flag is visible the cycle after the 64th wait cycle following adc_start.
        chk("t4_timeout_gap", to_rise_cyc - dead_start_cyc, 65);
        chk("t4_res_cnt", log_ch.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < log_ch.size()) chk("t4_ch_lit", log_ch[i], t4_exp[i]);
        dead_en = 1'b0;

        // Reset while ch1 conversion is in WAIT_DONE.
        adc_lat = 10;
        model_pass(4'b1111);
        base = starts_seen;
        start_scan(4'b1111, 1'b1, 1'b0);
        n = 0;
        while (starts_seen < base + 2 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t5_second_start", (starts_seen >= base + 2) ? 1 : 0, 1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_flags", int'({bus.adc_start, bus.res_valid, bus.scan_done,
                                  bus.seq_busy, bus.timeout_err}), 0);
        chk("t5_rst_regs", int'(bus.mux_sel) + int'(bus.res_ch) + int'(bus.res_data), 0);
        chk("t5_pending_res", exp_res_q.size(), 3);
        exp_start_q.delete();
        exp_res_q.delete();
        exp_done--;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_post_idle", int'(bus.seq_busy), 0);
        check_model("t5");
        adc_lat = 3;

        // Fresh scan after reset recovers normally.
        log_ch.delete(); log_data.delete();
        model_pass(4'b0100);
        start_scan(4'b0100, 1'b1, 1'b0);
        wait_idle("t6_idle", 200);
        check_model("t6");
        chk("t6_res_cnt", log_data.size(), 1);
        if (log_data.size() > 0) chk("t6_data_lit", log_data[0], 37);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_scan_sequencer.md
ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4, number of analog mux channels (2..8).
REQ-002 Parameter DATA_W, default 8, SAR conversion result width.
REQ-003 Parameter SETTLE_CYCLES, default 4, mux settling delay in clocks before each conversion (>=1).
REQ-004 Parameter TIMEOUT_CYCLES, default 64, max clocks from adc_start to adc_valid.
REQ-005 clk  input  1  single system clock, all logic rising-edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 enable  input  1  level; 1 = scanning permitted.
REQ-008 single_shot  input  1  level, sampled at scan start; 1 = stop after one scan pass.
REQ-009 ch_mask  input  NUM_CH  channel enable bits, sampled at scan start.
REQ-010 adc_start  output  1  one-cycle start pulse to SAR ADC.
REQ-011 adc_busy  input  1  SAR ADC busy.
REQ-012 adc_valid  input  1  SAR ADC result valid.
REQ-013 adc_data  input  DATA_W  SAR ADC result.
REQ-014 mux_sel  output  clog2(NUM_CH)  analog mux channel select.
REQ-015 res_valid  output  1  one-cycle pulse, res_ch/res_data valid.
REQ-016 res_ch  output  clog2(NUM_CH)  channel of delivered result.
REQ-017 res_data  output  DATA_W  captured conversion result.
REQ-018 scan_done  output  1  one-cycle pulse after last enabled channel of a pass.
REQ-019 seq_busy  output  1  high in every state except IDLE.
REQ-020 timeout_err  output  1  sticky, set on ADC timeout, cleared only by reset.

Function
REQ-021 FSM states SHALL be IDLE, SETTLE, START, WAIT_BUSY, WAIT_DONE, NEXT.
REQ-022 IDLE->SETTLE when enable=1 and ch_mask!=0; mask and single_shot latched that cycle; mux_sel = lowest set mask bit.
REQ-023 enable=1 with ch_mask=0 SHALL remain in IDLE, no adc_start.
REQ-024 SETTLE counts exactly SETTLE_CYCLES clocks, then ->START; mux_sel stable throughout SETTLE..WAIT_DONE.
REQ-025 START asserts adc_start for exactly one clock, then ->WAIT_BUSY; timeout counter cleared.
REQ-026 WAIT_BUSY->WAIT_DONE on adc_busy=1; WAIT_DONE->NEXT on adc_valid=1 with adc_busy=0.
REQ-027 adc_valid SHALL be honoured in WAIT_BUSY too (ADC finishing without visible busy) ->NEXT.
REQ-028 In NEXT, res_valid pulses one clock with res_data = adc_data captured on the adc_valid edge and res_ch = current mux_sel.
REQ-029 NEXT selects next higher set bit of latched mask ->SETTLE; if none, pulse scan_done same cycle.
REQ-030 End of pass: single_shot latched 1 or enable=0 ->IDLE; else re-latch ch_mask/single_shot, wrap to lowest set bit ->SETTLE (new mask 0 ->IDLE).
REQ-031 enable deassertion mid-pass SHALL not abort; current pass completes.
REQ-032 Timeout counter runs in WAIT_BUSY/WAIT_DONE; reaching TIMEOUT_CYCLES sets timeout_err, no res_valid for that channel, continues as NEXT.
REQ-033 adc_valid outside WAIT_BUSY/WAIT_DONE SHALL be ignored.
REQ-034 res_valid and scan_done SHALL never assert without a preceding adc_start in the same pass.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, counters 0, mux_sel 0, adc_start 0, res_valid 0, res_ch 0, res_data 0, scan_done 0, seq_busy 0, timeout_err 0.
REQ-036 Reset mid-conversion SHALL discard the in-flight result; first post-reset action requires a fresh IDLE->SETTLE.
REQ-037 Reset deassertion takes effect at next rising clk; no output toggles in the deassertion cycle.

Structure
REQ-038 Shared package adc_pkg holds FSM state enum, DATA_W default and channel-index width function.
REQ-039 One sub-module adc_chan_pick (combinational next-set-bit finder over mask from a start index, with found flag); rest flat.

Verification
REQ-040 mask=4'b1111, single_shot=1, data=ch*16+5 -> res_valid for ch0..3 with 5,21,37,53 in order, one scan_done, then IDLE.
REQ-041 mask=4'b1010, single_shot=0, enable dropped during ch3 -> ch1,ch3,ch1,ch3 results, ends IDLE after pass with enable low.
REQ-042 SETTLE_CYCLES=4 -> exactly 4 clocks between mux_sel change and adc_start; one adc_start per channel.
REQ-043 ADC model never asserts adc_valid on ch2 -> timeout_err set after 64 clocks, no res_valid ch2, ch3 still converted.
REQ-044 rst_n pulled low in WAIT_DONE -> all outputs reset immediately, no res_valid for that channel.
REQ-045 enable=1, mask=0 for 20 clocks -> no adc_start, seq_busy=0.
